// File: rtl/control_pkg.sv
// Shared definitions for the RV32I multi-cycle sequencer: opcodes, state
// encoding, fault causes and datapath select encodings.
package control_pkg;

    // Major opcodes, instruction[6:0]
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] LUI      = 7'b0110111;
    localparam logic [6:0] AUIPC    = 7'b0010111;
    localparam logic [6:0] OP       = 7'b0110011;
    localparam logic [6:0] JAL      = 7'b1101111;
    localparam logic [6:0] JALR     = 7'b1100111;
    localparam logic [6:0] BRANCH   = 7'b1100011;
    localparam logic [6:0] LOAD     = 7'b0000011;
    localparam logic [6:0] STORE    = 7'b0100011;
    localparam logic [6:0] MISC_MEM = 7'b0001111;
    localparam logic [6:0] SYSTEM   = 7'b1110011;

    // Sequencer states; the encoding is visible on the state port
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        MULDIV = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6,
        FAULT  = 3'd7
    } state_t;

    // Fault causes
    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b10;

    // Write-data mux selects
    localparam logic [1:0] WD_ALU    = 2'b00;
    localparam logic [1:0] WD_PC4    = 2'b01;
    localparam logic [1:0] WD_MULDIV = 2'b10;
    localparam logic [1:0] WD_MEM    = 2'b11;

    // ALU operation used outside write-back (plain add)
    localparam logic [4:0] ALU_ADD = 5'b00000;

    // ALU operation during write-back. Only OP and the shift-right
    // immediates use bit30 to pick the alternate operation.
    function automatic logic [4:0] wb_alu_op(input logic [6:0] op,
                                             input logic [2:0] f3,
                                             input logic       b30);
        if (op == OP || (op == OP_IMM && f3 == 3'b101))
            return {1'b0, b30, f3};
        else if (op == OP_IMM)
            return {2'b00, f3};
        else if (op == BRANCH)
            return {2'b10, f3};
        else
            return ALU_ADD;
    endfunction

endpackage

// File: rtl/control_fsm_bus_watchdog.sv
// Memory-access watchdog. Counts consecutive un-acked request cycles and
// flags expiry on the cycle that would bring the count to all-ones, so an
// access faults after 2^TIMEOUT_W-1 un-acked cycles.
module bus_watchdog #(
    parameter int TIMEOUT_W = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic waiting,
    output logic expired
);

    localparam logic [TIMEOUT_W-1:0] LAST = ~TIMEOUT_W'(1);

    logic [TIMEOUT_W-1:0] count;

    assign expired = waiting && (count == LAST);

    // Count un-acked cycles; zero whenever no access is outstanding
    always_ff @(posedge clk) begin
        if (reset || clear)
            count <= '0;
        else if (waiting && !expired)
            count <= count + TIMEOUT_W'(1);
    end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle sequencer for the RV32I core. Optional mul/div sequencing is
// built when CONTROL_MULDIV_EN is defined.
//
// Memory handshake: mem_req is held high, with mem_addr_sel and mem_we
// stable, for every cycle spent in FETCH or MEM. mem_ack may rise in the same
// cycle as mem_req; the access completes at the clock edge where both are
// high. mem_ack outside FETCH/MEM is ignored.
module control_fsm
    import control_pkg::*;
#(
    parameter int TIMEOUT_W = 4,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             bit20,
    input  logic             bit25,
    input  logic             bit30,
    input  logic             cmp_out,
    input  logic             mem_ack,
    input  logic             muldiv_done,
    output logic [2:0]       state,
    output logic             halted,
    output logic             fault,
    output logic [1:0]       fault_cause,
    output logic             pc_enable,
    output logic             pc_load,
    output logic             reg_re,
    output logic             reg_we,
    output logic             target_load,
    output logic             inst_load,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             muldiv_start,
    output logic             retire,
    output logic             alu_sel1,
    output logic             alu_sel2,
    output logic [4:0]       alu_op,
    output logic [1:0]       wd_sel,
    output logic [CNT_W-1:0] instret
);

    state_t cur;
    logic   in_access;
    logic   wd_expired;
    logic   is_muldiv;

    assign state     = cur;
    assign in_access = (cur == FETCH) || (cur == MEM);

`ifdef CONTROL_MULDIV_EN
    logic muldiv_issued;
    assign is_muldiv    = (opcode == OP) && bit25;
    assign muldiv_start = (cur == MULDIV) && !muldiv_issued;
`else
    logic unused_muldiv_done;
    assign unused_muldiv_done = muldiv_done;
    assign is_muldiv    = 1'b0;
    assign muldiv_start = 1'b0;
`endif

    bus_watchdog #(.TIMEOUT_W(TIMEOUT_W)) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (!in_access || mem_ack),
        .waiting (in_access && !mem_ack),
        .expired (wd_expired)
    );

    // State transitions, sticky status flags and the retired counter
    always_ff @(posedge clk) begin
        if (reset) begin
            cur         <= FETCH;
            halted      <= 1'b0;
            fault       <= 1'b0;
            fault_cause <= CAUSE_NONE;
            instret     <= '0;
`ifdef CONTROL_MULDIV_EN
            muldiv_issued <= 1'b0;
`endif
        end else begin
            if (retire)
                instret <= instret + CNT_W'(1);
`ifdef CONTROL_MULDIV_EN
            muldiv_issued <= (cur == MULDIV);
`endif
            case (cur)
                FETCH, MEM: begin
                    // ack wins over a simultaneous watchdog expiry
                    if (mem_ack) begin
                        cur <= (cur == FETCH) ? DECODE : WB;
                    end else if (wd_expired) begin
                        cur         <= FAULT;
                        fault       <= 1'b1;
                        fault_cause <= CAUSE_TIMEOUT;
                    end
                end
                DECODE: begin
                    case (opcode)
                        SYSTEM: begin
                            if (bit20) begin
                                cur    <= HALT;
                                halted <= 1'b1;
                            end else begin
                                cur <= WB;
                            end
                        end
                        LOAD, STORE, JALR: cur <= EXEC;
                        OP: begin
                            if (!bit25) begin
                                cur <= WB;
                            end else begin
`ifdef CONTROL_MULDIV_EN
                                cur <= MULDIV;
`else
                                cur         <= FAULT;
                                fault       <= 1'b1;
                                fault_cause <= CAUSE_ILLEGAL;
`endif
                            end
                        end
                        OP_IMM, LUI, AUIPC, JAL, BRANCH, MISC_MEM: cur <= WB;
                        default: begin
                            cur         <= FAULT;
                            fault       <= 1'b1;
                            fault_cause <= CAUSE_ILLEGAL;
                        end
                    endcase
                end
                EXEC: cur <= (opcode == JALR) ? WB : MEM;
`ifdef CONTROL_MULDIV_EN
                MULDIV: begin
                    if (muldiv_done)
                        cur <= WB;
                end
`endif
                WB: cur <= FETCH;
                default: cur <= cur;
            endcase
        end
    end

    // Datapath strobes decoded from the current state and instruction
    always_comb begin
        pc_enable    = 1'b0;
        pc_load      = 1'b0;
        reg_re       = 1'b0;
        reg_we       = 1'b0;
        target_load  = 1'b0;
        inst_load    = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        retire       = 1'b0;
        alu_sel1     = 1'b0;
        alu_sel2     = 1'b0;
        alu_op       = ALU_ADD;
        wd_sel       = WD_ALU;
        case (cur)
            FETCH: begin
                mem_req   = 1'b1;
                inst_load = mem_ack;
            end
            DECODE: begin
                reg_re      = 1'b1;
                target_load = 1'b1;
                alu_sel1    = 1'b1;
                alu_sel2    = 1'b1;
            end
            EXEC: begin
                alu_sel2    = 1'b1;
                target_load = (opcode == JALR);
            end
            MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (opcode == STORE);
            end
            WB: begin
                pc_enable = 1'b1;
                retire    = 1'b1;
                reg_we    = (opcode == OP_IMM) || (opcode == LUI) || (opcode == OP) ||
                            (opcode == AUIPC) || (opcode == JAL) || (opcode == JALR) ||
                            (opcode == LOAD);
                pc_load   = ((opcode == BRANCH) && cmp_out) || (opcode == JAL) ||
                            (opcode == JALR);
                if (opcode == JAL || opcode == JALR)
                    wd_sel = WD_PC4;
                else if (opcode == LOAD)
                    wd_sel = WD_MEM;
                else if (is_muldiv)
                    wd_sel = WD_MULDIV;
                if (opcode == AUIPC) begin
                    alu_sel1 = 1'b1;
                    alu_sel2 = 1'b1;
                end else if (opcode == OP_IMM || opcode == LUI) begin
                    alu_sel2 = 1'b1;
                end
                alu_op = wb_alu_op(opcode, funct3, bit30);
            end
            default: begin
            end
        endcase
    end

endmodule

// File: doc/control_fsm.md
# control_fsm

Parametrised multi-cycle sequencer for the RV32I core. It replaces the fixed four-step counter with a state machine that handles variable memory latency (request/acknowledge), a bus watchdog, illegal-opcode faults and an instruction-retired counter. It drives the same datapath controls (PC, register file, ALU, target register, write-data mux, memory, instruction register) from decoded instruction fields.

## Interface
- TIMEOUT_W, 4: width of the watchdog counter. A memory access faults after 2^TIMEOUT_W−1 un-acked cycles.
- CNT_W, 32: width of `instret`.
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- opcode  in  7  instruction[6:0]
- funct3  in  3  instruction[14:12]
- bit20 / bit25 / bit30  in  1 each  instruction bits 20, 25, 30
- cmp_out  in  1  branch comparator result
- mem_ack  in  1  memory completes the current request this cycle
- muldiv_done  in  1  mul/div unit result valid (used only with the macro)
- state  out  3  current state encoding
- halted / fault  out  1 each  sticky status flags
- fault_cause  out  2  01 = bus timeout, 10 = illegal opcode, 00 = none
- pc_enable, pc_load, reg_re, reg_we, target_load, inst_load, mem_req, mem_we, mem_addr_sel, muldiv_start, retire  out  1 each
- alu_sel1, alu_sel2  out  1 each
- alu_op  out  5
- wd_sel  out  2
- instret  out  CNT_W  retired-instruction count

## Operation
- States: FETCH, DECODE, EXEC, MEM, MULDIV, WB, HALT, FAULT.
- **FETCH**
  - Outputs: mem_req=1, mem_addr_sel=0.
  - When mem_ack=1: inst_load=1 and the next state is DECODE.
- **DECODE**
  - Outputs: reg_re=1, target_load=1, alu_sel1=1, alu_sel2=1.
  - SYSTEM with bit20 → HALT.
  - LOAD, STORE, JALR → EXEC.
  - OP with bit25 → MULDIV (macro builds only).
  - OP_IMM, LUI, AUIPC, OP, JAL, BRANCH, MISC_MEM, other SYSTEM → WB.
  - Any other opcode → FAULT with cause 10.
- **EXEC**
  - Outputs: alu_sel1=0, alu_sel2=1. For JALR, target_load=1.
  - LOAD/STORE → MEM. JALR → WB.
- **MEM**
  - Outputs: mem_req=1, mem_addr_sel=1, mem_we = (opcode==STORE).
  - When mem_ack=1: LOAD → WB; STORE → WB.
- **WB**
  - pc_enable=1 and retire=1. Next state is FETCH.
  - reg_we=1 for OP_IMM, LUI, OP, AUIPC, JAL, JALR, LOAD.
  - pc_load = (BRANCH && cmp_out) || JAL || JALR.
  - wd_sel: 01 for JAL/JALR, 11 for LOAD, 10 for mul/div, else 00.
  - alu_sel1/alu_sel2: 1/1 for AUIPC; 0/1 for OP_IMM and LUI; else 0/0.
  - alu_op:
    - OP, or OP_IMM with funct3=101: {0, bit30, funct3}.
    - Other OP_IMM: {0, 0, funct3}.
    - BRANCH: {1, 0, funct3}.
    - Otherwise: 0.
- **HALT, FAULT**: absorbing until reset. All strobes are 0 in these states.
- Outputs not listed for a state are 0.
- **Watchdog**
  - Clears on entry to FETCH or MEM.
  - Increments each cycle in FETCH or MEM while mem_ack=0.
  - At all-ones with mem_ack still 0 → FAULT with cause 01.
- **instret**
  - Increments on every cycle where retire=1.
  - Wraps modulo 2^CNT_W.
- mem_ack outside FETCH and MEM is ignored.

## Timing
- Reset values:
  - state=FETCH; instret=0; watchdog=0.
  - halted=0, fault=0, fault_cause=00.
  - All strobes are combinational from state, so mem_req=1 in the first cycle after reset.
- mem_ack may be asserted combinationally in the same cycle as mem_req; it takes effect at that clock edge.
- Latency with zero-wait memory:
  - ALU/branch/JAL: 3 cycles (FETCH, DECODE, WB).
  - JALR: 4 cycles.
  - LOAD/STORE: 5 cycles.
- Each memory wait cycle adds 1 cycle.
- mem_req stays high, with address select and mem_we stable, until the ack cycle.
- Reset mid-access: state returns to FETCH on the next edge. mem_we must not assert in the cycle after reset.
- Simultaneous mem_ack and watchdog expiry: the ack wins and there is no fault.
- halted and fault are set on the edge entering HALT or FAULT, and clear only on reset.

## Configuration
- CONTROL_MULDIV_EN defined:
  - The MULDIV state is built.
  - muldiv_start pulses for exactly the first cycle in MULDIV.
  - The FSM waits for muldiv_done, then goes to WB with reg_we=1 and wd_sel=10.
- Undefined:
  - MULDIV is absent and muldiv_start is tied to 0.
  - OP with bit25=1 goes to FAULT with cause 10.

## Structure
- control_pkg holds:
  - opcode localparams (OP_IMM, LUI, AUIPC, OP, JAL, JALR, BRANCH, LOAD, STORE, MISC_MEM, SYSTEM);
  - the state typedef;
  - fault-cause codes;
  - the alu_op and wd_sel encodings.
- One sub-module, bus_watchdog (parameter TIMEOUT_W). Ports: clk, reset, clear, waiting, expired.

## Test plan
- ADDI with mem_ack always 1 → states FETCH, DECODE, WB; reg_we=1 and alu_op=00000 in WB; instret=1 after 3 cycles.
- LW with fetch ack delayed 2 cycles and MEM ack delayed 1 → 8 cycles total; wd_sel=11 and reg_we=1 in WB; inst_load is high only in the fetch ack cycle.
- BEQ with cmp_out=1 → WB shows pc_load=1, alu_op=10000, reg_we=0. With cmp_out=0 → pc_load=0 and pc_enable=1.
- mem_ack held 0 with TIMEOUT_W=4 → FAULT after 15 FETCH cycles, fault_cause=01. Ack in cycle 15 → no fault.
- Opcode 0x7F → FAULT with cause 10. Then ECALL-with-bit20 (EBREAK) after reset → HALT, halted=1, pc_enable stays 0.
- Reset asserted during a STORE in MEM → FETCH next cycle, mem_we=0, instret=0. With CONTROL_MULDIV_EN: MUL, muldiv_done after 4 cycles → muldiv_start is a 1-cycle pulse, wd_sel=10 in WB.
